// File: rtl/cmp_pkg.sv
// Shared types and helpers for the comparator-sharing arbiter: FSM state encoding,
// id-width helper and the round-robin search used to pick the next requester.
package cmp_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } cmp_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of valid at or after ptr, wrapping at nreq-1 back to 0.
    function automatic pick_t rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                      input int unsigned nreq);
        pick_t       res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            cand = (32'(ptr) + k) % nreq;
            if ((k < nreq) && !res.found && valid[cand[2:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[2:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_bitwise.sv
// Existing W-bit equality comparator: z is high when every bit of x matches y.
module bitwise #(
    parameter int W = 2
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         z
);

    // Full-width bitwise match, no extension of either operand.
    always_comb begin
        z = &(~(x ^ y));
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin share of one equality comparator among NREQ requesters, with a
// single registered response slot and a saturating count of equal results.
module cmp_share_arbiter
    import cmp_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int W     = 2,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_x,
    input  logic [NREQ*W-1:0]       req_y,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_eq,
    output logic [id_w(NREQ)-1:0]   rsp_id,
    output logic [CNT_W-1:0]        match_cnt,
    output logic                    busy
);

    localparam int ID_W = id_w(NREQ);

    cmp_state_t        r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [NREQ-1:0]   r_rsp_valid;
    logic              r_rsp_eq;
    logic [ID_W-1:0]   r_rsp_id;
    logic [CNT_W-1:0]  r_match_cnt;
    logic              r_busy;

    pick_t             w_pick;
    logic              w_grant_ok;
    logic              w_grant;
    logic [ID_W-1:0]   w_gid;
    logic [ID_W-1:0]   w_next_ptr;
    logic [NREQ-1:0]   w_onehot;
    logic [W-1:0]      w_x;
    logic [W-1:0]      w_y;
    logic              w_z;
    logic              w_complete;

    // Grant search: the slot may accept when empty or when its response drains now.
    always_comb begin
        w_grant_ok = (r_state == IDLE) || rsp_ready;
        w_pick     = rr_pick(8'(req_valid), 3'(r_rr_ptr), NREQ);
        w_grant    = w_grant_ok && w_pick.found;
        w_gid      = ID_W'(w_pick.idx);
        w_onehot   = NREQ'(1) << w_gid;
        if (w_gid == ID_W'(NREQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_gid + ID_W'(1);
        end
    end

    // Accept strobe back to the winning requester only.
    always_comb begin
        if (w_grant) begin
            req_ready = w_onehot;
        end else begin
            req_ready = '0;
        end
    end

    // Grant mux feeding the shared comparator.
    always_comb begin
        w_x = req_x[w_gid*W +: W];
        w_y = req_y[w_gid*W +: W];
    end

    bitwise #(.W(W)) u_cmp (
        .x (w_x),
        .y (w_y),
        .z (w_z)
    );

    // A response completes on the edge where the slot is full and rsp_ready is high.
    always_comb begin
        w_complete = (r_state == RESP) && rsp_ready;
    end

    // Slot FSM with registered response outputs and the saturating match counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
            r_rsp_eq    <= 1'b0;
            r_rsp_id    <= '0;
            r_match_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (w_complete && r_rsp_eq && (r_match_cnt != {CNT_W{1'b1}})) begin
                r_match_cnt <= r_match_cnt + CNT_W'(1);
            end else begin
                r_match_cnt <= r_match_cnt;
            end
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state     <= RESP;
                        r_rsp_eq    <= w_z;
                        r_rsp_id    <= w_gid;
                        r_rr_ptr    <= w_next_ptr;
                        r_rsp_valid <= w_onehot;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state     <= IDLE;
                    end
                end
                RESP: begin
                    if (w_grant) begin
                        r_state     <= RESP;
                        r_rsp_eq    <= w_z;
                        r_rsp_id    <= w_gid;
                        r_rr_ptr    <= w_next_ptr;
                        r_rsp_valid <= w_onehot;
                        r_busy      <= 1'b1;
                    end else if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= '0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_state     <= RESP;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_eq    = r_rsp_eq;
    assign rsp_id    = r_rsp_id;
    assign match_cnt = r_match_cnt;
    assign busy      = r_busy;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Randomized and directed bench for cmp_share_arbiter against a slot/queue-level
// reference model; a second instance with a 2-bit counter covers saturation.
module tb_cmp_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_valid = 4'b0000;
    logic [7:0] req_x = 8'h00;
    logic [7:0] req_y = 8'h00;
    logic       rsp_ready = 1'b0;

    logic [3:0] req_ready,  req_ready2;
    logic [3:0] rsp_valid,  rsp_valid2;
    logic       rsp_eq,     rsp_eq2;
    logic [1:0] rsp_id,     rsp_id2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    logic       busy,       busy2;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: one response slot, round-robin pointer, two counters.
    int m_ptr;
    bit m_full;
    int m_id;
    bit m_eq;
    int m_cnt8;
    int m_cnt2;
    int m_g;

    cmp_share_arbiter #(.NREQ(4), .W(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_eq(rsp_eq), .rsp_id(rsp_id), .match_cnt(match_cnt), .busy(busy)
    );

    cmp_share_arbiter #(.NREQ(4), .W(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_eq(rsp_eq2), .rsp_id(rsp_id2), .match_cnt(match_cnt2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ptr = 0; m_full = 0; m_id = 0; m_eq = 0; m_cnt8 = 0; m_cnt2 = 0; m_g = -1;
    endtask

    function automatic int m_pick();
        int idx;
        if (m_full && !rsp_ready) return -1;
        for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_all();
        logic [3:0] exp_rdy;
        logic [3:0] exp_vld;
        m_g = m_pick();
        exp_rdy = (m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
        exp_vld = m_full ? (4'b0001 << m_id) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("req_ready_sat", 32'(req_ready2), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
        chk("rsp_valid_sat", 32'(rsp_valid2), 32'(exp_vld));
        chk("busy", 32'(busy), 32'(m_full));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt8));
        chk("match_cnt_sat", 32'(match_cnt2), 32'(m_cnt2));
        if (m_full) begin
            chk("rsp_eq", 32'(rsp_eq), 32'(m_eq));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end
    endtask

    task automatic m_update();
        int gx;
        int gy;
        if (m_full && rsp_ready && m_eq) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (m_g >= 0) begin
            gx = (req_x >> (2 * m_g)) & 3;
            gy = (req_y >> (2 * m_g)) & 3;
            m_full = 1; m_id = m_g; m_eq = (gx == gy); m_ptr = (m_g + 1) % 4;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
    endtask

    // One clock: apply inputs in the low phase, check, advance the model at the edge.
    task automatic cycle(input logic [3:0] v, input logic [7:0] x, input logic [7:0] y,
                         input logic rr);
        req_valid = v; req_x = x; req_y = y; rsp_ready = rr;
        #1;
        check_all();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'b0000; rsp_ready = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();
        #2;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_eq", 32'(rsp_eq), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_match_cnt", 32'(match_cnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single equal request from requester 0.
        cycle(4'b0001, 8'h03, 8'h03, 1'b0);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_eq", 32'(rsp_eq), 32'h1);
        chk("t1_rsp_id", 32'(rsp_id), 32'h0);
        cycle(4'b0000, 8'h00, 8'h00, 1'b1);
        cycle(4'b0000, 8'h00, 8'h00, 1'b0);
        chk("t1_match_cnt", 32'(match_cnt), 32'h1);

        // Mismatch from requester 2.
        cycle(4'b0100, 8'h30, 8'h20, 1'b0);
        chk("t2_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t2_rsp_eq", 32'(rsp_eq), 32'h0);
        chk("t2_rsp_id", 32'(rsp_id), 32'h2);
        cycle(4'b0000, 8'h00, 8'h00, 1'b1);
        cycle(4'b0000, 8'h00, 8'h00, 1'b0);
        chk("t2_match_cnt", 32'(match_cnt), 32'h1);

        // All requesters valid with the sink always ready, then backpressure.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 8'($urandom), 8'($urandom), 1'b1);
            chk("t3_rsp_id", 32'(rsp_id), 32'(i % 4));
        end
        for (int i = 0; i < 3; i++) cycle(4'b1111, 8'($urandom), 8'($urandom), 1'b0);
        chk("t4_rsp_id_held", 32'(rsp_id), 32'h0);
        cycle(4'b1111, 8'($urandom), 8'($urandom), 1'b1);
        chk("t4_next_grant", 32'(rsp_id), 32'h1);
        cycle(4'b0000, 8'h00, 8'h00, 1'b1);

        // Saturation of the 2-bit counter after five equal responses.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(4'b1111, 8'h55, 8'h55, 1'b1);
        cycle(4'b0000, 8'h00, 8'h00, 1'b1);
        cycle(4'b0000, 8'h00, 8'h00, 1'b0);
        chk("t5_cnt_sat", 32'(match_cnt2), 32'h3);
        chk("t5_cnt_wide", 32'(match_cnt), 32'h5);

        // Asynchronous reset while a response is pending.
        cycle(4'b0010, 8'h0C, 8'h0C, 1'b0);
        chk("t6_pending", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_match_cnt", 32'(match_cnt), 32'h0);
        chk("t6_match_cnt_sat", 32'(match_cnt2), 32'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1111; rsp_ready = 1'b1;
        #1;
        chk("t6_first_grant", 32'(req_ready), 32'h1);
        cycle(4'b1111, 8'($urandom), 8'($urandom), 1'b1);

        // Random traffic with valids dropping and backpressure.
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
